// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter, its fetch/load-store requesters and the shared memory.
// slave = arbiter view; master = requesters plus memory view.
interface mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_ready;
  logic            if_err;
  logic [XLEN-1:0] if_rdata;

  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [3:0]      d_byte_en;
  logic            d_ready;
  logic            d_err;
  logic [XLEN-1:0] d_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_byte_en;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_ready, if_err, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_byte_en,
    output d_ready, d_err, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en,
    input  mem_ready, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_ready, if_err, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_byte_en,
    input  d_ready, d_err, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch vs. load/store arbiter for one variable-latency memory port, with a per-transaction watchdog.
// Optional: define MEM_ARB_ROUND_ROBIN_EN to break ties toward the requester that lost the last grant.
module mem_arbiter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;
  logic            if_ready_q, if_ready_d;
  logic            if_err_q, if_err_d;
  logic            d_ready_q, d_ready_d;
  logic            d_err_q, d_err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic            last_grant_q, last_grant_d;
`endif

  logic if_want, d_want, pick_data;

  // A requester whose err pulse is on this cycle has not yet had a chance to drop req.
  always_comb begin
    if_want = bus.if_req & ~if_err_q;
    d_want  = bus.d_req & ~d_err_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pick_data = d_want & (~if_want | ~last_grant_q);
`else
    pick_data = d_want;
`endif
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wd_d        = wd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    if_err_d    = 1'b0;
    d_ready_d   = 1'b0;
    d_err_d     = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (if_want | d_want) begin
          owner_d   = pick_data;
          mem_req_d = 1'b1;
          state_d   = BUSY;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = pick_data;
`endif
          if (pick_data) begin
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            mem_be_d    = bus.d_byte_en;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            mem_be_d    = 4'b1111;
          end
        end
      end

      BUSY: begin
        wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
        // Completion is checked first so a same-cycle mem_ready beats the watchdog.
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (owner_q) begin
            d_rdata_d = bus.mem_rdata;
            d_ready_d = 1'b1;
          end else begin
            if_rdata_d = bus.mem_rdata;
            if_ready_d = 1'b1;
          end
        end else if (wd_q == WD_LAST) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (owner_q) d_err_d  = 1'b1;
          else         if_err_d = 1'b1;
        end
      end

      RESP: begin
        wd_d    = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      wd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      if_err_q    <= 1'b0;
      d_ready_q   <= 1'b0;
      d_err_q     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wd_q        <= wd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      if_err_q    <= if_err_d;
      d_ready_q   <= d_ready_d;
      d_err_q     <= d_err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_byte_en = mem_be_q;
  assign bus.if_ready    = if_ready_q;
  assign bus.if_err      = if_err_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.d_ready     = d_ready_q;
  assign bus.d_err       = d_err_q;
  assign bus.d_rdata     = d_rdata_q;

endmodule
